// File: rtl/chess_pkg.sv
// Shared piece codes, controller state encoding and colour helpers for the
// board datapath front end.
package chess_pkg;

  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    B_PAWN   = 4'd1,
    B_KNIGHT = 4'd2,
    B_BISHOP = 4'd3,
    B_ROOK   = 4'd4,
    B_QUEEN  = 4'd5,
    B_KING   = 4'd6,
    W_PAWN   = 4'd7,
    W_KNIGHT = 4'd8,
    W_BISHOP = 4'd9,
    W_ROOK   = 4'd10,
    W_QUEEN  = 4'd11,
    W_KING   = 4'd12
  } piece_t;

  typedef enum logic [3:0] {
    S_BOOT,
    S_INIT_WAIT,
    S_SEL_ORIGIN,
    S_RD_ORIGIN,
    S_CHK_ORIGIN,
    S_SEL_DEST,
    S_RD_DEST,
    S_CHK_DEST,
    S_MOVE,
    S_MOVE_WAIT,
    S_TURN
  } state_t;

  function automatic logic is_white(input logic [3:0] p);
    return (p >= W_PAWN) && (p <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] p);
    return (p >= B_PAWN) && (p <= B_KING);
  endfunction

  // Codes 13..15 fall through both colour tests and count as empty.
  function automatic logic is_empty(input logic [3:0] p);
    return !is_white(p) && !is_black(p);
  endfunction

  // turn: 0 = white to move, 1 = black to move.
  function automatic logic owned_by(input logic [3:0] p, input logic turn);
    return turn ? is_black(p) : is_white(p);
  endfunction

endpackage

// File: rtl/move_controller_if.sv
// Key, board-memory and datapath handshake bundle of the move controller.
interface move_controller_if;
  logic       key_up, key_down, key_left, key_right, key_select, key_cancel;
  logic [2:0] mem_rd_x, mem_rd_y;
  logic [3:0] mem_rd_data;
  logic       initialize_board, initialize_complete;
  logic       move_piece, move_complete;
  logic [2:0] origin_x, origin_y, destination_x, destination_y;
  logic [3:0] piece_to_move;
  logic [2:0] cursor_x, cursor_y;
  logic       selected, turn, busy;

  modport master (
    input  key_up, key_down, key_left, key_right, key_select, key_cancel,
    input  mem_rd_data, initialize_complete, move_complete,
    output mem_rd_x, mem_rd_y, initialize_board, move_piece,
    output origin_x, origin_y, destination_x, destination_y, piece_to_move,
    output cursor_x, cursor_y, selected, turn, busy
  );

  modport slave (
    output key_up, key_down, key_left, key_right, key_select, key_cancel,
    output mem_rd_data, initialize_complete, move_complete,
    input  mem_rd_x, mem_rd_y, initialize_board, move_piece,
    input  origin_x, origin_y, destination_x, destination_y, piece_to_move,
    input  cursor_x, cursor_y, selected, turn, busy
  );
endinterface

// File: rtl/move_controller_cursor_ctrl.sv
// 3-bit x/y cursor with wrap or saturate at the board edge and fixed key
// priority select > cancel > up > down > left > right.
module cursor_ctrl #(
  parameter int CURSOR_WRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  input  logic       i_select,
  input  logic       i_cancel,
  output logic [2:0] o_x,
  output logic [2:0] o_y
);
  localparam logic WRAP = (CURSOR_WRAP != 0);

  logic [2:0] r_x, r_y;

  function automatic logic [2:0] dec(input logic [2:0] v);
    return (v == 3'd0) ? (WRAP ? 3'd7 : 3'd0) : v - 3'd1;
  endfunction

  function automatic logic [2:0] inc(input logic [2:0] v);
    return (v == 3'd7) ? (WRAP ? 3'd0 : 3'd7) : v + 3'd1;
  endfunction

  // select/cancel outrank every direction, so they suppress movement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en && !i_select && !i_cancel) begin
      if (i_up)         r_y <= dec(r_y);
      else if (i_down)  r_y <= inc(r_y);
      else if (i_left)  r_x <= dec(r_x);
      else if (i_right) r_x <= inc(r_x);
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
endmodule

// File: rtl/move_controller.sv
// Turns key pulses into a cursor, origin/destination selection and a single
// move command, with colour-ownership checks read from board memory.
module move_controller
  import chess_pkg::*;
#(
  parameter int WHITE_FIRST = 1,
  parameter int CURSOR_WRAP = 1,
  parameter int RD_LATENCY  = 1
) (
  input logic               clk,
  input logic               reset,
  move_controller_if.master bus
);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);
  localparam logic       TURN_RST = (WHITE_FIRST != 0) ? 1'b0 : 1'b1;

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_init, r_move, r_sel, r_turn, r_busy;
  logic [2:0] r_ox, r_oy, r_dx, r_dy, r_mx, r_my;
  logic [3:0] r_piece;
  logic [2:0] w_cx, w_cy;
  logic       w_cur_en, w_on_origin;

  assign w_cur_en    = (r_state == S_SEL_ORIGIN) || (r_state == S_SEL_DEST);
  assign w_on_origin = (w_cx == r_ox) && (w_cy == r_oy);

  cursor_ctrl #(.CURSOR_WRAP(CURSOR_WRAP)) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_cur_en),
    .i_up     (bus.key_up),
    .i_down   (bus.key_down),
    .i_left   (bus.key_left),
    .i_right  (bus.key_right),
    .i_select (bus.key_select),
    .i_cancel (bus.key_cancel),
    .o_x      (w_cx),
    .o_y      (w_cy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mx <= '0;
      r_my <= '0;
    end else begin
      r_mx <= w_cx;
      r_my <= w_cy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_cnt   <= '0;
      r_init  <= 1'b0;
      r_move  <= 1'b0;
      r_sel   <= 1'b0;
      r_turn  <= TURN_RST;
      r_busy  <= 1'b1;
      r_ox    <= '0;
      r_oy    <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_piece <= '0;
    end else begin
      r_init <= 1'b0;
      r_move <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_init  <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= S_INIT_WAIT;
        end
        S_INIT_WAIT: if (bus.initialize_complete) begin
          r_busy  <= 1'b0;
          r_state <= S_SEL_ORIGIN;
        end
        S_SEL_ORIGIN: if (bus.key_select) begin
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RD_ORIGIN;
        end
        S_RD_ORIGIN: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == LAT_LAST) r_state <= S_CHK_ORIGIN;
        end
        S_CHK_ORIGIN: begin
          r_busy <= 1'b0;
          if (owned_by(bus.mem_rd_data, r_turn)) begin
            r_ox    <= w_cx;
            r_oy    <= w_cy;
            r_piece <= bus.mem_rd_data;
            r_sel   <= 1'b1;
            r_state <= S_SEL_DEST;
          end else begin
            r_state <= S_SEL_ORIGIN;
          end
        end
        S_SEL_DEST: begin
          // Re-selecting the origin square behaves exactly like cancel.
          if (bus.key_select && !w_on_origin) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_RD_DEST;
          end else if (bus.key_select || bus.key_cancel) begin
            r_sel   <= 1'b0;
            r_state <= S_SEL_ORIGIN;
          end
        end
        S_RD_DEST: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == LAT_LAST) r_state <= S_CHK_DEST;
        end
        S_CHK_DEST: begin
          if (owned_by(bus.mem_rd_data, r_turn)) begin
            r_busy  <= 1'b0;
            r_state <= S_SEL_DEST;
          end else begin
            r_dx    <= w_cx;
            r_dy    <= w_cy;
            r_state <= S_MOVE;
          end
        end
        S_MOVE: begin
          r_move  <= 1'b1;
          r_state <= S_MOVE_WAIT;
        end
        S_MOVE_WAIT: if (bus.move_complete) r_state <= S_TURN;
        S_TURN: begin
          r_turn  <= ~r_turn;
          r_sel   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_SEL_ORIGIN;
        end
        default: r_state <= S_BOOT;
      endcase
    end
  end

  assign bus.mem_rd_x         = r_mx;
  assign bus.mem_rd_y         = r_my;
  assign bus.initialize_board = r_init;
  assign bus.move_piece       = r_move;
  assign bus.origin_x         = r_ox;
  assign bus.origin_y         = r_oy;
  assign bus.destination_x    = r_dx;
  assign bus.destination_y    = r_dy;
  assign bus.piece_to_move    = r_piece;
  assign bus.cursor_x         = w_cx;
  assign bus.cursor_y         = w_cy;
  assign bus.selected         = r_sel;
  assign bus.turn             = r_turn;
  assign bus.busy             = r_busy;
endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench: DUT A uses wrap/latency 1, DUT B saturate/latency 3.
module tb_move_controller;

  localparam logic [5:0] K_UP  = 6'b000001;
  localparam logic [5:0] K_DN  = 6'b000010;
  localparam logic [5:0] K_LT  = 6'b000100;
  localparam logic [5:0] K_RT  = 6'b001000;
  localparam logic [5:0] K_SEL = 6'b010000;
  localparam logic [5:0] K_CAN = 6'b100000;

  typedef struct {
    int ox, oy, dx, dy, piece, turn;
  } mv_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  move_controller_if ifa ();
  move_controller_if ifb ();

  move_controller #(.WHITE_FIRST(1), .CURSOR_WRAP(1), .RD_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa)
  );
  move_controller #(.WHITE_FIRST(1), .CURSOR_WRAP(0), .RD_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb)
  );

  logic [3:0] board_a [64];
  logic [3:0] board_b [64];
  logic [3:0] pb1, pb2;

  always @(posedge clk) begin
    ifa.mem_rd_data <= board_a[{ifa.mem_rd_y, ifa.mem_rd_x}];
    pb1             <= board_b[{ifb.mem_rd_y, ifb.mem_rd_x}];
    pb2             <= pb1;
    ifb.mem_rd_data <= pb2;
  end

  mv_t mq_a[$], mq_b[$];
  int  iq_a[$], iq_b[$];
  mv_t ea, eb;
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic mv_t mk(input int ox, oy, dx, dy, piece, turn);
    mv_t m;
    m.ox = ox; m.oy = oy; m.dx = dx; m.dy = dy; m.piece = piece; m.turn = turn;
    return m;
  endfunction

  function automatic int idx(input int x, input int y);
    return y * 8 + x;
  endfunction

  always @(negedge clk) begin
    if (ifa.initialize_board) begin
      chk("init_a_expected", (iq_a.size() > 0) ? 1 : 0, 1);
      if (iq_a.size() > 0) void'(iq_a.pop_front());
    end
    if (ifb.initialize_board) begin
      chk("init_b_expected", (iq_b.size() > 0) ? 1 : 0, 1);
      if (iq_b.size() > 0) void'(iq_b.pop_front());
    end
    if (ifa.move_piece) begin
      if (mq_a.size() == 0) chk("move_a_unexpected", 1, 0);
      else begin
        ea = mq_a.pop_front();
        chk("move_a_origin_x", int'(ifa.origin_x), ea.ox);
        chk("move_a_origin_y", int'(ifa.origin_y), ea.oy);
        chk("move_a_dest_x", int'(ifa.destination_x), ea.dx);
        chk("move_a_dest_y", int'(ifa.destination_y), ea.dy);
        chk("move_a_piece", int'(ifa.piece_to_move), ea.piece);
        chk("move_a_turn", int'(ifa.turn), ea.turn);
      end
    end
    if (ifb.move_piece) begin
      if (mq_b.size() == 0) chk("move_b_unexpected", 1, 0);
      else begin
        eb = mq_b.pop_front();
        chk("move_b_origin_x", int'(ifb.origin_x), eb.ox);
        chk("move_b_origin_y", int'(ifb.origin_y), eb.oy);
        chk("move_b_dest_x", int'(ifb.destination_x), eb.dx);
        chk("move_b_dest_y", int'(ifb.destination_y), eb.dy);
        chk("move_b_piece", int'(ifb.piece_to_move), eb.piece);
        chk("move_b_turn", int'(ifb.turn), eb.turn);
      end
    end
  end

  task automatic set_keys(input int d, input logic [5:0] m);
    if (d == 0) begin
      ifa.key_up = m[0]; ifa.key_down = m[1]; ifa.key_left = m[2];
      ifa.key_right = m[3]; ifa.key_select = m[4]; ifa.key_cancel = m[5];
    end else begin
      ifb.key_up = m[0]; ifb.key_down = m[1]; ifb.key_left = m[2];
      ifb.key_right = m[3]; ifb.key_select = m[4]; ifb.key_cancel = m[5];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int d, input logic [5:0] m);
    set_keys(d, m);
    tick(1);
    set_keys(d, 6'b0);
  endtask

  task automatic press_n(input int d, input logic [5:0] m, input int n);
    repeat (n) press(d, m);
  endtask

  // w: 0 = initialize_complete, 1 = move_complete
  task automatic pulse_in(input int d, input int w);
    if (d == 0) begin
      if (w == 0) ifa.initialize_complete = 1'b1; else ifa.move_complete = 1'b1;
    end else begin
      if (w == 0) ifb.initialize_complete = 1'b1; else ifb.move_complete = 1'b1;
    end
    tick(1);
    if (d == 0) begin
      ifa.initialize_complete = 1'b0; ifa.move_complete = 1'b0;
    end else begin
      ifb.initialize_complete = 1'b0; ifb.move_complete = 1'b0;
    end
  endtask

  // w: 0 = initialize_board, 1 = move_piece, 2 = not busy
  function automatic bit sig(input int d, input int w);
    if (d == 0) return (w == 0) ? ifa.initialize_board : (w == 1) ? ifa.move_piece : !ifa.busy;
    else        return (w == 0) ? ifb.initialize_board : (w == 1) ? ifb.move_piece : !ifb.busy;
  endfunction

  task automatic wait_for(input int d, input int w, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (sig(d, w)) seen = 1'b1;
      else tick(1);
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_keys(0, 6'b0);
    set_keys(1, 6'b0);
    ifa.initialize_complete = 1'b0; ifa.move_complete = 1'b0;
    ifb.initialize_complete = 1'b0; ifb.move_complete = 1'b0;
    for (int i = 0; i < 64; i++) begin
      board_a[i] = 4'd0;
      board_b[i] = 4'd0;
    end
    board_a[idx(4, 6)] = 4'd7;
    board_a[idx(0, 1)] = 4'd1;
    board_a[idx(0, 7)] = 4'd10;
    board_a[idx(1, 7)] = 4'd8;
    board_b[idx(7, 0)] = 4'd11;
    board_b[idx(5, 0)] = 4'd1;
    tick(2);

    chk("rst_busy", int'(ifa.busy), 1);
    chk("rst_init", int'(ifa.initialize_board), 0);
    chk("rst_turn", int'(ifa.turn), 0);
    chk("rst_selected", int'(ifa.selected), 0);
    chk("rst_cursor_x", int'(ifa.cursor_x), 0);

    iq_a.push_back(1);
    rst_a = 1'b0;
    wait_for(0, 0, "boot_init_a");
    pulse_in(0, 0);
    chk("boot_busy", int'(ifa.busy), 0);
    chk("boot_turn", int'(ifa.turn), 0);
    chk("boot_cursor_y", int'(ifa.cursor_y), 0);

    press(0, K_RT);
    chk("right_once", int'(ifa.cursor_x), 1);
    press_n(0, K_RT, 7);
    chk("right_wrap", int'(ifa.cursor_x), 0);
    press(0, K_UP);
    chk("up_wrap", int'(ifa.cursor_y), 7);
    press(0, K_DN);
    chk("down_wrap", int'(ifa.cursor_y), 0);
    press(0, K_LT | K_RT);
    chk("prio_left_over_right", int'(ifa.cursor_x), 7);
    press(0, K_RT);
    press(0, K_UP | K_DN);
    chk("prio_up_over_down", int'(ifa.cursor_y), 7);
    press(0, K_DN);

    // white pawn (4,6) -> (4,4)
    press_n(0, K_RT, 4);
    press_n(0, K_UP, 2);
    press(0, K_SEL);
    wait_for(0, 2, "w_origin_ready");
    chk("w_selected", int'(ifa.selected), 1);
    chk("w_piece", int'(ifa.piece_to_move), 7);
    press_n(0, K_UP, 2);
    mq_a.push_back(mk(4, 6, 4, 4, 7, 0));
    press(0, K_SEL);
    wait_for(0, 1, "w_move_issued");
    press(0, K_RT);
    chk("keys_dropped_busy", int'(ifa.cursor_x), 4);
    pulse_in(0, 1);
    wait_for(0, 2, "w_turn_done");
    chk("w_turn_black", int'(ifa.turn), 1);
    chk("w_sel_cleared", int'(ifa.selected), 0);
    board_a[idx(4, 4)] = 4'd7;
    board_a[idx(4, 6)] = 4'd0;

    // black to move: white piece at cursor is rejected
    press(0, K_SEL);
    wait_for(0, 2, "b_rej_ready");
    chk("b_reject_white", int'(ifa.selected), 0);

    // black pawn (0,1) -> (0,2)
    press_n(0, K_LT, 4);
    press_n(0, K_UP, 3);
    press(0, K_SEL);
    wait_for(0, 2, "b_origin_ready");
    chk("b_selected", int'(ifa.selected), 1);
    chk("b_piece", int'(ifa.piece_to_move), 1);
    press(0, K_DN);
    mq_a.push_back(mk(0, 1, 0, 2, 1, 1));
    press(0, K_SEL);
    wait_for(0, 1, "b_move_issued");
    pulse_in(0, 1);
    wait_for(0, 2, "b_turn_done");
    chk("b_turn_white", int'(ifa.turn), 0);
    board_a[idx(0, 2)] = 4'd1;
    board_a[idx(0, 1)] = 4'd0;

    // white to move: black pawn at (0,2) rejected
    press(0, K_SEL);
    wait_for(0, 2, "w_rej_ready");
    chk("w_reject_black", int'(ifa.selected), 0);

    // origin (0,7) held, own piece at (1,7) rejected as destination
    press_n(0, K_UP, 3);
    press(0, K_SEL);
    wait_for(0, 2, "rook_ready");
    chk("rook_selected", int'(ifa.selected), 1);
    press(0, K_RT);
    press(0, K_SEL);
    wait_for(0, 2, "own_dest_ready");
    chk("own_dest_keeps_sel", int'(ifa.selected), 1);
    chk("own_dest_keeps_piece", int'(ifa.piece_to_move), 10);
    press(0, K_LT);
    press(0, K_SEL);
    wait_for(0, 2, "reselect_ready");
    chk("reselect_origin_clears", int'(ifa.selected), 0);
    press(0, K_SEL);
    wait_for(0, 2, "rook_ready2");
    chk("rook_selected2", int'(ifa.selected), 1);
    press(0, K_CAN);
    chk("cancel_clears", int'(ifa.selected), 0);
    chk("cancel_not_busy", int'(ifa.busy), 0);

    // reset while waiting for move_complete
    press(0, K_SEL);
    wait_for(0, 2, "rook_ready3");
    press(0, K_DN);
    mq_a.push_back(mk(0, 7, 0, 0, 10, 0));
    press(0, K_SEL);
    wait_for(0, 1, "rst_move_issued");
    #5;
    rst_a = 1'b1;
    #1;
    chk("arst_selected", int'(ifa.selected), 0);
    chk("arst_busy", int'(ifa.busy), 1);
    chk("arst_origin_y", int'(ifa.origin_y), 0);
    chk("arst_piece", int'(ifa.piece_to_move), 0);
    chk("arst_move_piece", int'(ifa.move_piece), 0);
    iq_a.push_back(1);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    wait_for(0, 0, "reboot_init_a");
    pulse_in(0, 1);
    chk("late_complete_busy", int'(ifa.busy), 1);
    chk("late_complete_turn", int'(ifa.turn), 0);
    pulse_in(0, 0);
    chk("reboot_busy", int'(ifa.busy), 0);

    // DUT B: saturating cursor, read latency 3
    iq_b.push_back(1);
    rst_b = 1'b0;
    wait_for(1, 0, "boot_init_b");
    pulse_in(1, 0);
    chk("b_boot_busy", int'(ifb.busy), 0);
    press_n(1, K_RT, 8);
    chk("sat_right", int'(ifb.cursor_x), 7);
    press(1, K_UP);
    chk("sat_up", int'(ifb.cursor_y), 0);

    press(1, K_LT); press(1, K_LT); press(1, K_RT); press(1, K_RT);
    press(1, K_SEL);
    tick(3);
    chk("lat_origin_not_early", int'(ifb.selected), 0);
    tick(1);
    chk("lat_origin_on_time", int'(ifb.selected), 1);
    chk("lat_origin_piece", int'(ifb.piece_to_move), 11);

    board_b[idx(6, 0)] = 4'd7;
    press(1, K_LT);
    press(1, K_LT);
    mq_b.push_back(mk(7, 0, 5, 0, 11, 0));
    press(1, K_SEL);
    wait_for(1, 1, "capture_issued");
    pulse_in(1, 1);
    wait_for(1, 2, "capture_done");
    chk("capture_turn", int'(ifb.turn), 1);
    chk("capture_sel_cleared", int'(ifb.selected), 0);

    tick(2);
    chk("moves_a_pending", mq_a.size(), 0);
    chk("moves_b_pending", mq_b.size(), 0);
    chk("inits_a_pending", iq_a.size(), 0);
    chk("inits_b_pending", iq_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
